sdram_playback_reader: RTL

SDRAM_PLAYBACK_READER -- requirements
Module: sdram_playback_reader

---
 rtl/sdram_playback_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sdram_playback_reader.sv
// sdram_playback_reader: credit-limited Avalon-MM burst reader feeding a show-ahead sample FIFO.
module sdram_playback_reader #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Loop,
    input  logic [24:0] Base_Address,
    input  logic [24:0] Length,
    output logic        Avalon_ChipEnable,
    output logic [1:0]  Avalon_ByteEnable,
    output logic [24:0] Avalon_Address,
    output logic        Avalon_Read,
    input  logic        Avalon_WaitRequest,
    input  logic [15:0] Avalon_ReadData,
    input  logic        Avalon_ReadDataValid,
    output logic [15:0] Sample_Data,
    output logic        Sample_Valid,
    input  logic        Sample_Ready,
    output logic        Busy,
    output logic        Underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    typedef enum logic [1:0] {IDLE, READ, DONE, FLUSH} state_t;
    state_t state_q, state_d;
    logic [24:0] addr_q, addr_d, base_q, base_d, len_q, len_d, idx_q, idx_d;
    logic loop_q, loop_d, read_q, read_d, stop_pend_q, stop_pend_d, underflow_q, underflow_d;
    logic [AW:0] out_q, out_d, cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0] mem [FIFO_DEPTH];
    logic accept, ret, push, pop, start_ok, last, credit_ok;
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        loop_d      = loop_q;
        read_d      = read_q;
        stop_pend_d = stop_pend_q;
        accept      = read_q & ~Avalon_WaitRequest;
        ret         = Avalon_ReadDataValid & (out_q != '0);
        push        = ret & (state_q != FLUSH);
        pop         = (cnt_q != '0) & Sample_Ready;
        start_ok    = (state_q == IDLE) & Start & ~Stop & (Length != '0);
        last        = idx_q == len_q - 25'd1;
        out_d       = out_q + (AW+1)'(accept) - (AW+1)'(ret);
        cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        // Credit covers both in-flight reads and buffered words so returns always fit.
        credit_ok   = ({1'b0, out_d} + {1'b0, cnt_d}) < CW'(FIFO_DEPTH);
        underflow_d = start_ok ? 1'b0 : underflow_q | ((state_q == READ) & Sample_Ready & (cnt_q == '0));
        case (state_q)
            IDLE: if (start_ok) begin
                state_d     = READ;
                read_d      = 1'b1;
                addr_d      = Base_Address;
                base_d      = Base_Address;
                len_d       = Length;
                loop_d      = Loop;
                idx_d       = '0;
                stop_pend_d = 1'b0;
            end
            READ: if (accept) begin
                addr_d = (last & loop_q) ? base_q : addr_q + 25'd1;
                idx_d  = last ? '0 : idx_q + 25'd1;
                if (stop_pend_q | Stop) begin
                    read_d  = 1'b0;
                    state_d = FLUSH;
                end else if (last & ~loop_q) begin
                    read_d  = 1'b0;
                    state_d = DONE;
                end else
                    read_d = credit_ok;
            end else if (read_q)
                stop_pend_d = stop_pend_q | Stop;
            else if (Stop)
                state_d = FLUSH;
            else
                read_d = credit_ok;
            DONE: state_d = Stop ? FLUSH : ((out_d == '0) & (cnt_d == '0)) ? IDLE : DONE;
            FLUSH: state_d = (out_d == '0) ? IDLE : FLUSH;
            default: ;
        endcase
        if (state_d == FLUSH) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            loop_q      <= 1'b0;
            read_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            underflow_q <= 1'b0;
            out_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            loop_q      <= loop_d;
            read_q      <= read_d;
            stop_pend_q <= stop_pend_d;
            underflow_q <= underflow_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr_q] <= Avalon_ReadData;
    end
    assign Avalon_ChipEnable = 1'b1;
    assign Avalon_ByteEnable = 2'b11;
    assign Avalon_Address    = addr_q;
    assign Avalon_Read       = read_q;
    assign Sample_Data       = mem[rd_ptr_q];
    assign Sample_Valid      = cnt_q != '0;
    assign Busy              = state_q != IDLE;
    assign Underflow         = underflow_q;
endmodule
